// File: rtl/ei_axi4_interface_if.sv
// ei_axi4_interface_if: AXI4 five-channel signal bundle with master and slave views
interface ei_axi4_interface_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid, bid, arid, rid;
  logic [ADDR_WIDTH-1:0]   awaddr, araddr;
  logic [7:0]              awlen, arlen;
  logic [2:0]              awsize, arsize;
  logic [1:0]              awburst, arburst, bresp, rresp;
  logic [DATA_WIDTH-1:0]   wdata, rdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, rvalid, rready, rlast;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/ei_axi4_interface.sv
// ei_axi4_interface: AXI4 slave endpoint backed by a byte-addressed memory, one outstanding burst per direction
module ei_axi4_interface #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_BYTES  = 4096
) (
  input logic aclk,
  input logic aresetn,
  ei_axi4_interface_if.slave axi
);
  localparam int STRB = DATA_WIDTH / 8;
  localparam int SB = $clog2(STRB);
  localparam int MB = $clog2(MEM_BYTES);
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [ADDR_WIDTH:0] wide_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  localparam addr_t ONE = addr_t'(1);

  logic [7:0] mem [MEM_BYTES];

  function automatic addr_t nbytes(input logic [2:0] size);
    return ONE << size;
  endfunction

  function automatic addr_t wrap_bytes(input logic [7:0] len, input logic [2:0] size);
    return nbytes(size) * (addr_t'(len) + ONE);
  endfunction

  function automatic addr_t next_addr(input addr_t a, input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    addr_t b = nbytes(size);
    addr_t w = wrap_bytes(len, size);
    addr_t lower = a & ~(w - ONE);
    addr_t nxt = a + b;
    return burst == 2'b00 ? a : burst == 2'b10 ? (nxt == lower + w ? lower : nxt) : (a & ~(b - ONE)) + b;
  endfunction

  // The whole burst footprint is known at the address handshake, so the error is decided once there
  function automatic logic bad(input addr_t a, input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    addr_t b = nbytes(size);
    addr_t w = wrap_bytes(len, size);
    wide_t first = wide_t'(a & ~(b - ONE));
    wide_t last = burst == 2'b00 ? wide_t'(a) :
                  burst == 2'b10 ? wide_t'(a & ~(w - ONE)) + wide_t'(w - b) :
                  first + wide_t'(b) * wide_t'(len);
    return burst == 2'b11 || int'(size) > SB ||
           (burst == 2'b10 && (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || (a & (b - ONE)) != '0)) ||
           last >= wide_t'(MEM_BYTES) ||
           (burst == 2'b01 && first[ADDR_WIDTH:12] != last[ADDR_WIDTH:12]);
  endfunction

  function automatic logic lane_on(input addr_t a, input logic [2:0] size, input int i);
    int lo = int'(a[SB-1:0]);
    int hi = lo + int'(nbytes(size)) - int'(a & (nbytes(size) - ONE)) - 1;
    return i >= lo && i <= hi;
  endfunction

  function automatic logic [MB-1:0] midx(input addr_t a, input int i);
    return MB'((a & ~addr_t'(STRB - 1)) + addr_t'(i));
  endfunction

  w_state_e w_state_q, w_state_d;
  logic [ID_WIDTH-1:0] wid_q, wid_d;
  addr_t waddr_q, waddr_d;
  logic [7:0] wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0] wsize_q, wsize_d;
  logic [1:0] wburst_q, wburst_d;
  logic werr_q, werr_d;

  always_comb begin
    w_state_d = w_state_q;
    wid_d = wid_q;
    waddr_d = waddr_q;
    wlen_d = wlen_q;
    wcnt_d = wcnt_q;
    wsize_d = wsize_q;
    wburst_d = wburst_q;
    werr_d = werr_q;
    if (w_state_q == W_IDLE && axi.awvalid) begin
      w_state_d = W_DATA;
      wid_d = axi.awid;
      waddr_d = axi.awaddr;
      wlen_d = axi.awlen;
      wsize_d = axi.awsize;
      wburst_d = axi.awburst;
      wcnt_d = '0;
      werr_d = bad(axi.awaddr, axi.awlen, axi.awsize, axi.awburst);
    end
    if (w_state_q == W_DATA && axi.wvalid) begin
      waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
      wcnt_d = wcnt_q + 8'd1;
      w_state_d = wcnt_q == wlen_q ? W_RESP : W_DATA;
    end
    if (w_state_q == W_RESP && axi.bready) w_state_d = W_IDLE;
  end

  always_ff @(posedge aclk)
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      wid_q <= '0;
      waddr_q <= '0;
      wlen_q <= '0;
      wcnt_q <= '0;
      wsize_q <= '0;
      wburst_q <= '0;
      werr_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wid_q <= wid_d;
      waddr_q <= waddr_d;
      wlen_q <= wlen_d;
      wcnt_q <= wcnt_d;
      wsize_q <= wsize_d;
      wburst_q <= wburst_d;
      werr_q <= werr_d;
    end

  always_ff @(posedge aclk)
    if (aresetn && w_state_q == W_DATA && axi.wvalid && !werr_q)
      for (int i = 0; i < STRB; i++)
        if (axi.wstrb[i] && lane_on(waddr_q, wsize_q, i)) mem[midx(waddr_q, i)] <= axi.wdata[8*i +: 8];

  r_state_e r_state_q, r_state_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  addr_t raddr_q, raddr_d;
  logic [7:0] rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0] rsize_q, rsize_d;
  logic [1:0] rburst_q, rburst_d;
  logic rerr_q, rerr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic load;

  // rdata is fetched for the beat being entered, so it reads memory before any same-edge write lands
  always_comb begin
    r_state_d = r_state_q;
    rid_d = rid_q;
    raddr_d = raddr_q;
    rlen_d = rlen_q;
    rcnt_d = rcnt_q;
    rsize_d = rsize_q;
    rburst_d = rburst_q;
    rerr_d = rerr_q;
    rdata_d = rdata_q;
    load = 1'b0;
    if (r_state_q == R_IDLE && axi.arvalid) begin
      r_state_d = R_DATA;
      rid_d = axi.arid;
      raddr_d = axi.araddr;
      rlen_d = axi.arlen;
      rsize_d = axi.arsize;
      rburst_d = axi.arburst;
      rcnt_d = '0;
      rerr_d = bad(axi.araddr, axi.arlen, axi.arsize, axi.arburst);
      load = 1'b1;
    end
    if (r_state_q == R_DATA && axi.rready) begin
      r_state_d = rcnt_q == rlen_q ? R_IDLE : R_DATA;
      raddr_d = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
      rcnt_d = rcnt_q + 8'd1;
      load = rcnt_q != rlen_q;
    end
    if (load)
      for (int i = 0; i < STRB; i++)
        rdata_d[8*i +: 8] = !rerr_d && lane_on(raddr_d, rsize_d, i) ? mem[midx(raddr_d, i)] : 8'h00;
  end

  always_ff @(posedge aclk)
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      rid_q <= '0;
      raddr_q <= '0;
      rlen_q <= '0;
      rcnt_q <= '0;
      rsize_q <= '0;
      rburst_q <= '0;
      rerr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      r_state_q <= r_state_d;
      rid_q <= rid_d;
      raddr_q <= raddr_d;
      rlen_q <= rlen_d;
      rcnt_q <= rcnt_d;
      rsize_q <= rsize_d;
      rburst_q <= rburst_d;
      rerr_q <= rerr_d;
      rdata_q <= rdata_d;
    end

  logic unused_wlast;
  assign unused_wlast = axi.wlast;

  assign axi.awready = w_state_q == W_IDLE;
  assign axi.wready = w_state_q == W_DATA;
  assign axi.bvalid = w_state_q == W_RESP;
  assign axi.bid = wid_q;
  assign axi.bresp = {w_state_q == W_RESP && werr_q, 1'b0};
  assign axi.arready = r_state_q == R_IDLE;
  assign axi.rvalid = r_state_q == R_DATA;
  assign axi.rid = rid_q;
  assign axi.rdata = rdata_q;
  assign axi.rresp = {r_state_q == R_DATA && rerr_q, 1'b0};
  assign axi.rlast = r_state_q == R_DATA && rcnt_q == rlen_q;
endmodule

// File: tb/tb_ei_axi4_interface.sv
// tb_ei_axi4_interface: directed AXI4 bursts with a queue scoreboard checked on every B and R handshake
module tb_ei_axi4_interface;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass = 0;
  int total = 0;
  logic [5:0] bq[$];
  logic [38:0] rq[$];
  logic [31:0] ed[$];

  ei_axi4_interface_if axi();
  ei_axi4_interface dut (.aclk(clk), .aresetn(rst_n), .axi(axi.slave));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clk)
    if (rst_n) begin
      if (axi.bvalid && axi.bready) begin
        if (bq.size() == 0) chk("b_unexpected", 64'(bq.size()), 64'd1);
        else chk("b_id_resp", {58'd0, axi.bid, axi.bresp}, {58'd0, bq.pop_front()});
      end
      if (axi.rvalid && axi.rready) begin
        if (rq.size() == 0) chk("r_unexpected", 64'(rq.size()), 64'd1);
        else chk("r_id_data_resp_last", {25'd0, axi.rid, axi.rdata, axi.rresp, axi.rlast}, {25'd0, rq.pop_front()});
      end
    end

  task automatic hs(input int ch);
    logic ok;
    int n = 0;
    do begin
      @(negedge clk);
      ok = ch == 0 ? axi.awready : ch == 1 ? axi.wready : axi.arready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    chk($sformatf("ready_ch%0d", ch), {63'd0, ok}, 64'd1);
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                    input logic [1:0] burst, input logic [31:0] d0, input logic [31:0] step, input logic [3:0] strb,
                    input logic [1:0] resp, input int bhold);
    int n = 0;
    bq.push_back({id, resp});
    axi.awid = id;
    axi.awaddr = addr;
    axi.awlen = len;
    axi.awsize = size;
    axi.awburst = burst;
    axi.awvalid = 1'b1;
    hs(0);
    axi.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      axi.wdata = d0 + 32'(i) * step;
      axi.wstrb = strb;
      axi.wlast = i == int'(len);
      axi.wvalid = 1'b1;
      hs(1);
    end
    axi.wvalid = 1'b0;
    for (int k = 0; k < bhold; k++) begin
      @(negedge clk);
      chk("bp_bvalid", {63'd0, axi.bvalid}, 64'd1);
      chk("bp_awready", {63'd0, axi.awready}, 64'd0);
      @(posedge clk);
      #1;
    end
    axi.bready = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bq.size() > 0 && n < 50);
    axi.bready = 1'b0;
    chk("b_done", 64'(bq.size()), 64'd0);
    bq.delete();
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                    input logic [1:0] burst, input logic [1:0] resp, input bit rnd);
    int n = 0;
    for (int i = 0; i <= int'(len); i++) rq.push_back({id, ed[i], resp, i == int'(len)});
    ed.delete();
    axi.arid = id;
    axi.araddr = addr;
    axi.arlen = len;
    axi.arsize = size;
    axi.arburst = burst;
    axi.arvalid = 1'b1;
    hs(2);
    axi.arvalid = 1'b0;
    do begin
      axi.rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      n++;
    end while (rq.size() > 0 && n < 400);
    axi.rready = 1'b0;
    chk("r_done", 64'(rq.size()), 64'd0);
    rq.delete();
  endtask

  initial begin
    {axi.awvalid, axi.wvalid, axi.wlast, axi.bready, axi.arvalid, axi.rready} = '0;
    {axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst} = '0;
    {axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst} = '0;
    axi.wdata = '0;
    axi.wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", {63'd0, axi.awready}, 64'd1);
    chk("rst_arready", {63'd0, axi.arready}, 64'd1);
    chk("rst_wready", {63'd0, axi.wready}, 64'd0);
    chk("rst_bvalid", {63'd0, axi.bvalid}, 64'd0);
    chk("rst_rvalid", {63'd0, axi.rvalid}, 64'd0);
    chk("rst_rlast_rdata", {31'd0, axi.rlast, axi.rdata}, 64'd0);
    rst_n = 1'b1;
    wr(4'h3, 32'h100, 8'd3, 3'd2, 2'b01, 32'h11111111, 32'h11111111, 4'hF, 2'b00, 0);
    ed = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    rd(4'h5, 32'h100, 8'd3, 3'd2, 2'b01, 2'b00, 1'b0);
    ed = {32'h33333333, 32'h44444444, 32'h11111111, 32'h22222222};
    rd(4'h6, 32'h108, 8'd3, 3'd2, 2'b10, 2'b00, 1'b0);
    wr(4'h1, 32'h200, 8'd0, 3'd2, 2'b01, 32'h0, 32'h0, 4'hF, 2'b00, 0);
    wr(4'h2, 32'h200, 8'd0, 3'd2, 2'b01, 32'hAABBCCDD, 32'h0, 4'h5, 2'b00, 0);
    ed = {32'h00BB00DD};
    rd(4'h7, 32'h200, 8'd0, 3'd2, 2'b01, 2'b00, 1'b0);
    ed = {32'h00BB0000};
    rd(4'h8, 32'h202, 8'd0, 3'd0, 2'b01, 2'b00, 1'b0);
    wr(4'h4, 32'h202, 8'd0, 3'd1, 2'b01, 32'h12345678, 32'h0, 4'hF, 2'b00, 0);
    ed = {32'h123400DD};
    rd(4'h9, 32'h200, 8'd0, 3'd2, 2'b01, 2'b00, 1'b0);
    wr(4'h5, 32'h300, 8'd1, 3'd2, 2'b01, 32'h0, 32'h0, 4'hF, 2'b00, 0);
    wr(4'h6, 32'h300, 8'd3, 3'd2, 2'b00, 32'hA0A0A0A0, 32'h1, 4'hF, 2'b00, 0);
    ed = {32'hA0A0A0A3, 32'h00000000};
    rd(4'hA, 32'h300, 8'd1, 3'd2, 2'b01, 2'b00, 1'b0);
    wr(4'h7, 32'h100, 8'd0, 3'd2, 2'b11, 32'hDEADBEEF, 32'h0, 4'hF, 2'b10, 0);
    wr(4'h8, 32'h100, 8'd2, 3'd2, 2'b10, 32'hCAFE0000, 32'h1, 4'hF, 2'b10, 0);
    ed = {32'h11111111, 32'h22222222, 32'h33333333};
    rd(4'hB, 32'h100, 8'd2, 3'd2, 2'b01, 2'b00, 1'b0);
    ed = {32'h0, 32'h0, 32'h0, 32'h0};
    rd(4'hC, 32'h1000, 8'd3, 3'd2, 2'b01, 2'b10, 1'b0);
    ed = {32'h0};
    rd(4'hD, 32'h100, 8'd0, 3'd3, 2'b01, 2'b10, 1'b0);
    wr(4'h9, 32'h600, 8'd0, 3'd2, 2'b01, 32'h5A5A5A5A, 32'h0, 4'hF, 2'b00, 5);
    wr(4'hA, 32'h400, 8'd15, 3'd2, 2'b01, 32'h40000000, 32'h01010101, 4'hF, 2'b00, 0);
    for (int i = 0; i < 16; i++) ed.push_back(32'h40000000 + 32'(i) * 32'h01010101);
    rd(4'hE, 32'h400, 8'd15, 3'd2, 2'b01, 2'b00, 1'b1);
    axi.awid = 4'h1;
    axi.awaddr = 32'h500;
    axi.awlen = 8'd7;
    axi.awsize = 3'd2;
    axi.awburst = 2'b01;
    axi.awvalid = 1'b1;
    hs(0);
    axi.awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      axi.wdata = 32'h0BAD0000 + 32'(i);
      axi.wstrb = 4'hF;
      axi.wlast = 1'b0;
      axi.wvalid = 1'b1;
      hs(1);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    axi.wvalid = 1'b0;
    @(negedge clk);
    chk("midrst_awready", {63'd0, axi.awready}, 64'd1);
    chk("midrst_wready", {63'd0, axi.wready}, 64'd0);
    chk("midrst_bvalid", {63'd0, axi.bvalid}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr(4'hB, 32'h500, 8'd0, 3'd2, 2'b01, 32'h77777777, 32'h0, 4'hF, 2'b00, 0);
    ed = {32'h77777777};
    rd(4'hF, 32'h500, 8'd0, 3'd2, 2'b01, 2'b00, 1'b0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/ei_axi4_interface.md
Name: ei_axi4_interface

Overview:
AXI4 slave endpoint with a byte-addressed internal memory. It sits at the pin boundary of the AXI4 VIP: a master or VIP driver issues bursts on the five channels, and this block accepts them, stores and returns data, and produces responses. Reads and writes have independent state machines. Each direction allows one outstanding transaction.

Parameters:
ADDR_WIDTH, 32, AXADDR width
DATA_WIDTH, 32, RDATA/WDATA width (32 or 64); STRB = DATA_WIDTH/8
ID_WIDTH, 4, AWID/ARID/BID/RID width
MEM_BYTES, 4096, memory size in bytes (power of 2)

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  synchronous active-low reset
awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address channel
awvalid  in  1; awready  out  1
wdata/wstrb/wlast  in  DATA_WIDTH/STRB/1  write data
wvalid  in  1; wready  out  1
bid/bresp  out  ID_WIDTH/2; bvalid  out  1; bready  in  1
arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address channel
arvalid  in  1; arready  out  1
rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1; rvalid  out  1; rready  in  1

Behaviour:
- Reset: aresetn sampled low at the edge forces both FSMs to IDLE. Outputs after reset: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, rdata=0, bid=0, rid=0.
- Reset mid-burst aborts the burst immediately. Memory contents are not cleared.
- A transfer occurs on any edge where VALID and READY are both 1. The slave never waits for VALID before asserting READY. Once asserted, its own VALID outputs hold stable until the handshake.
- Write FSM:
  - W_IDLE (awready=1): on AW handshake, latch id, addr, len, size and burst; beat count=0; go to W_DATA.
  - W_DATA (wready=1): on each W handshake, write the bytes enabled by wstrb into memory at the current beat address, unless the transaction is in error. On the beat where count==len, go to W_RESP.
  - W_RESP (bvalid=1, bid=latched id): on B handshake, go to W_IDLE.
  - W data arriving before AW is not accepted (wready=0 in W_IDLE).
- Read FSM:
  - R_IDLE (arready=1): on AR handshake, latch fields; go to R_DATA.
  - R_DATA: rvalid=1. rdata comes from the current beat address and is registered, so the first beat appears 1 cycle after the AR handshake. rlast=1 on beat count==len. On each R handshake, advance to the next beat. After the last beat, go to R_IDLE.
- Address generation (bytes = 1<<size):
  - FIXED: every beat uses the start address.
  - INCR: beat0 = start address. Each next beat = (previous address aligned down to bytes) + bytes.
  - WRAP: wrap_bytes = bytes*(len+1); lower = addr & ~(wrap_bytes-1); next = addr+bytes, and if next == lower+wrap_bytes then next = lower.
- Byte lanes: lane = addr mod STRB. A narrow transfer uses lanes [lane, lane + bytes - (addr mod bytes) - 1]. wstrb bits outside these lanes are ignored. Read lanes outside the active range return 0.
- Errors give SLVERR (2'b10); otherwise OKAY (2'b00). Error cases:
  - burst == 2'b11
  - WRAP with len not in {1,3,7,15}, or with an unaligned start address
  - size > log2(STRB)
  - any beat address >= MEM_BYTES
  - INCR crossing a 4 KB boundary
- On error, the full burst is still accepted or returned with the correct beat count and rlast. Writes in an errored burst leave memory unchanged. Errored reads return rdata=0 with rresp=SLVERR on every beat. The error is decided at address handshake.
- wlast is not checked for correctness. The beat count alone ends the burst.
- Simultaneous read and write to the same address in the same cycle: the read returns the old data.

Test Plan:
- Reset: hold aresetn=0 for 3 cycles -> awready=1, arready=1, wready=0, bvalid=0, rvalid=0. Assert reset during a len=7 write -> FSMs return to IDLE; the next transaction runs normally.
- INCR write then read: write awaddr=0x100, len=3, size=2, data 0x11111111..0x44444444 with wstrb=0xF -> bresp=OKAY, bid=AWID. Read the same burst -> 4 beats with matching data, rlast only on beat 4, rid=ARID.
- WRAP read: araddr=0x108, len=3, size=2 -> beat addresses 0x108, 0x10C, 0x100, 0x104.
- Narrow/strobe: write 0xAABBCCDD at 0x200 with wstrb=0x5 over an initial value of 0 -> reading 0x200 returns 0x00BB00DD. A FIXED 4-beat write to 0x300 -> the last beat's data remains.
- Errors: awburst=2'b11 -> bresp=SLVERR and memory unchanged. araddr=MEM_BYTES -> every beat gives rresp=SLVERR, rdata=0, and rlast is correct.
- Backpressure: hold bready=0 for 5 cycles -> bvalid stays high and awready stays 0 until the handshake. Toggle rready randomly on a len=15 read -> all 16 beats are delivered in order with none dropped.
